// File: rtl/ready_valid_rr_arbiter_if.sv
// Handshake bundle for the two-master round-robin arbiter.
// The "slave" modport is the arbiter's view: it is the slave of both upstream
// masters and drives the shared downstream port. The "master" modport is the
// environment's view, which drives the masters and the downstream ready.
interface ready_valid_rr_arbiter_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] data1;
    logic                  master_valid1;
    logic                  slave_ready1;
    logic [DATA_WIDTH-1:0] data2;
    logic                  master_valid2;
    logic                  slave_ready2;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_valid;
    logic                  out_ready;
    logic [1:0]            grant;

    modport slave (
        input  data1, master_valid1, data2, master_valid2, out_ready,
        output slave_ready1, slave_ready2, out_data, out_valid, grant
    );

    modport master (
        output data1, master_valid1, data2, master_valid2, out_ready,
        input  slave_ready1, slave_ready2, out_data, out_valid, grant
    );
endinterface

// File: rtl/ready_valid_rr_arbiter.sv
// Two-master round-robin arbiter with burst locking in front of one shared
// ready/valid slave. The output is a single registered beat; a master is only
// told ready while it owns the port and that register can take a new beat.
module ready_valid_rr_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int MAX_BURST  = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    ready_valid_rr_arbiter_if.slave  bus
);
    localparam int CNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN1 = 2'd1,
        OWN2 = 2'd2
    } state_e;

    state_e                state, state_next;
    logic                  last_port2, last_port2_next;   // previous owner was port 2
    logic [CNT_W-1:0]      burst_cnt, burst_cnt_next;
    logic                  out_valid_q;
    logic [DATA_WIDTH-1:0] out_data_q;

    logic space, ready1, ready2, xfer1, xfer2;
    logic own_valid, other_valid;
    state_e other_state;

    // The buffer can accept a beat when empty or when its beat leaves this cycle.
    assign space  = !out_valid_q || bus.out_ready;
    assign ready1 = (state == OWN1) && space;
    assign ready2 = (state == OWN2) && space;
    assign xfer1  = bus.master_valid1 && ready1;
    assign xfer2  = bus.master_valid2 && ready2;

    assign bus.slave_ready1 = ready1;
    assign bus.slave_ready2 = ready2;
    assign bus.grant        = {state == OWN2, state == OWN1};
    assign bus.out_valid    = out_valid_q;
    assign bus.out_data     = out_data_q;

    // Owner-relative view so OWN1 and OWN2 share one set of rules.
    assign own_valid   = (state == OWN2) ? bus.master_valid2 : bus.master_valid1;
    assign other_valid = (state == OWN2) ? bus.master_valid1 : bus.master_valid2;
    assign other_state = (state == OWN1) ? OWN2 : OWN1;

    // Next owner, burst count and tie-break memory.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        state_next      = state;
        burst_cnt_next  = burst_cnt;
        last_port2_next = last_port2;
        unique case (state)
            IDLE: begin
                burst_cnt_next = '0;
                if (bus.master_valid1 && bus.master_valid2) begin
                    state_next = last_port2 ? OWN1 : OWN2;
                end else if (bus.master_valid1) begin
                    state_next = OWN1;
                end else if (bus.master_valid2) begin
                    state_next = OWN2;
                end
            end
            OWN1, OWN2: begin
                if (!own_valid) begin
                    state_next      = other_valid ? other_state : IDLE;
                    burst_cnt_next  = '0;
                    last_port2_next = (state == OWN2);
                end else if (xfer1 || xfer2) begin
                    if (burst_cnt == CNT_MAX) begin
                        // Burst used up: hand over only if someone is waiting,
                        // otherwise keep the grant with the count saturated.
                        if (other_valid) begin
                            state_next      = other_state;
                            burst_cnt_next  = '0;
                            last_port2_next = (state == OWN2);
                        end
                    end else begin
                        burst_cnt_next = burst_cnt + CNT_W'(1);
                    end
                end
                // A downstream stall holds both state and count.
            end
            default: state_next = IDLE;
        endcase
    end

    // Arbitration state register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (rst) begin
            state      <= IDLE;
            last_port2 <= 1'b1;
            burst_cnt  <= '0;
        end else begin
            state      <= state_next;
            last_port2 <= last_port2_next;
            burst_cnt  <= burst_cnt_next;
        end
    end

    // One-entry output stage: load on a transfer, empty when drained, data held otherwise.
    always_ff @(posedge clk) begin
        // NOTE: the data register is reset too, so the shared slave sees 0 rather than a stale beat.
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else if (xfer1 || xfer2) begin
            out_valid_q <= 1'b1;
            out_data_q  <= xfer2 ? bus.data2 : bus.data1;
        end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end
endmodule

// File: tb/tb_ready_valid_rr_arbiter.sv
// Bench for ready_valid_rr_arbiter: a per-cycle vector table, hand sequences for
// burst, stall, owner-drop and reset corners, then random traffic. Every cycle
// is also compared against a transaction-level model of the arbitration rules.
module tb_ready_valid_rr_arbiter;
    localparam int DW = 8;
    localparam int MB = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ready_valid_rr_arbiter_if #(.DATA_WIDTH(DW)) bus ();

    ready_valid_rr_arbiter #(.DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;
    bit model_chk = 1'b0;

    // Sampled DUT outputs of the latest cycle.
    logic [1:0]    s_grant;
    logic          s_sr1, s_sr2, s_ov, s_x1, s_x2;
    logic [DW-1:0] s_od;

    // Reference model: current owner (0 none, 1, 2), previous owner, beats
    // granted in the current turn, and the output buffer as a queue.
    int            m_owner, m_last, m_beats;
    logic [DW-1:0] m_buf[$];
    logic [DW-1:0] m_od;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // One clock cycle: drive inputs, sample, compare with the model, advance the model.
    task automatic step(input logic r, input logic v1, input logic [DW-1:0] d1,
                        input logic v2, input logic [DW-1:0] d2, input logic ordy);
        logic [1:0] p_grant;
        logic       p_space, p_sr1, p_sr2, p_ov;
        int         own, oth;
        bit         vo, vt;
        @(negedge clk);
        rst               = r;
        bus.master_valid1 = v1;
        bus.data1         = d1;
        bus.master_valid2 = v2;
        bus.data2         = d2;
        bus.out_ready     = ordy;
        #1;
        s_grant = bus.grant;
        s_sr1   = bus.slave_ready1;
        s_sr2   = bus.slave_ready2;
        s_ov    = bus.out_valid;
        s_od    = bus.out_data;
        s_x1    = v1 && s_sr1;
        s_x2    = v2 && s_sr2;

        p_grant = (m_owner == 1) ? 2'b01 : (m_owner == 2) ? 2'b10 : 2'b00;
        p_ov    = (m_buf.size() != 0);
        p_space = !p_ov || ordy;
        p_sr1   = (m_owner == 1) && p_space;
        p_sr2   = (m_owner == 2) && p_space;
        if (model_chk)
            check("cycle", 32'({s_grant, s_sr1, s_sr2, s_ov, s_od}),
                           32'({p_grant, p_sr1, p_sr2, p_ov, m_od}));

        if (r) begin
            m_owner = 0; m_last = 2; m_beats = 0; m_od = '0;
            m_buf.delete();
        end else begin
            if (p_ov && ordy) void'(m_buf.pop_front());
            if (v1 && p_sr1) begin m_buf.push_back(d1); m_od = d1; end
            if (v2 && p_sr2) begin m_buf.push_back(d2); m_od = d2; end
            if (m_owner == 0) begin
                m_beats = 0;
                if (v1 && v2)  m_owner = (m_last == 1) ? 2 : 1;
                else if (v1)   m_owner = 1;
                else if (v2)   m_owner = 2;
            end else begin
                own = m_owner;
                oth = 3 - own;
                vo  = (own == 1) ? v1 : v2;
                vt  = (own == 1) ? v2 : v1;
                if (!vo) begin
                    m_owner = vt ? oth : 0; m_beats = 0; m_last = own;
                end else if ((v1 && p_sr1) || (v2 && p_sr2)) begin
                    if (m_beats + 1 >= MB && vt) begin
                        m_owner = oth; m_beats = 0; m_last = own;
                    end else if (m_beats + 1 < MB) begin
                        m_beats++;
                    end
                end
            end
        end
    endtask

    task automatic reset_dut();
        step(1'b1, 1'b0, '0, 1'b0, '0, 1'b1);
        step(1'b1, 1'b0, '0, 1'b0, '0, 1'b1);
    endtask

    typedef struct packed {
        logic          rst, v1;
        logic [DW-1:0] d1;
        logic          v2;
        logic [DW-1:0] d2;
        logic          ordy;
        logic [1:0]    grant;
        logic          sr1, sr2, ov;
        logic [DW-1:0] od;
    } vec_t;

    vec_t          vecs[17];
    logic [DW-1:0] outq[$];
    logic [DW-1:0] seq1, seq2, exp_b;
    logic          mv1, mv2;
    logic [DW-1:0] md1, md2;
    int            drop_age, grp, idx;
    bit            got;

    initial begin
        // rst v1 d1 v2 d2 ordy | grant sr1 sr2 ov od   (outputs seen in that cycle)
        vecs[0]  = '{1'b1, 1'b1, 8'h11, 1'b1, 8'h77, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 8'h00};
        vecs[1]  = '{1'b0, 1'b1, 8'h11, 1'b0, 8'h00, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 8'h00};
        vecs[2]  = '{1'b0, 1'b1, 8'h11, 1'b0, 8'h00, 1'b1, 2'b01, 1'b1, 1'b0, 1'b0, 8'h00};
        vecs[3]  = '{1'b0, 1'b1, 8'h22, 1'b0, 8'h00, 1'b1, 2'b01, 1'b1, 1'b0, 1'b1, 8'h11};
        vecs[4]  = '{1'b0, 1'b1, 8'h33, 1'b0, 8'h00, 1'b1, 2'b01, 1'b1, 1'b0, 1'b1, 8'h22};
        vecs[5]  = '{1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 2'b01, 1'b1, 1'b0, 1'b1, 8'h33};
        vecs[6]  = '{1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 8'h33};
        vecs[7]  = '{1'b0, 1'b1, 8'h44, 1'b1, 8'h55, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 8'h33};
        vecs[8]  = '{1'b0, 1'b1, 8'h44, 1'b1, 8'h55, 1'b1, 2'b10, 1'b0, 1'b1, 1'b0, 8'h33};
        vecs[9]  = '{1'b0, 1'b1, 8'h44, 1'b0, 8'h00, 1'b1, 2'b10, 1'b0, 1'b1, 1'b1, 8'h55};
        vecs[10] = '{1'b0, 1'b1, 8'h44, 1'b0, 8'h00, 1'b1, 2'b01, 1'b1, 1'b0, 1'b0, 8'h55};
        vecs[11] = '{1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 2'b01, 1'b0, 1'b0, 1'b1, 8'h44};
        vecs[12] = '{1'b0, 1'b1, 8'h66, 1'b0, 8'h00, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 8'h44};
        vecs[13] = '{1'b0, 1'b1, 8'h66, 1'b0, 8'h00, 1'b0, 2'b01, 1'b0, 1'b0, 1'b1, 8'h44};
        vecs[14] = '{1'b0, 1'b1, 8'h66, 1'b0, 8'h00, 1'b1, 2'b01, 1'b1, 1'b0, 1'b1, 8'h44};
        vecs[15] = '{1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 2'b01, 1'b1, 1'b0, 1'b1, 8'h66};
        vecs[16] = '{1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 8'h66};

        // First reset cycle: outputs are not defined yet, so nothing is compared.
        step(1'b1, 1'b1, 8'h11, 1'b1, 8'h77, 1'b1);
        model_chk = 1'b1;

        // Reset, single master, tie after port 1 owned last, owner drop, stalls.
        foreach (vecs[i]) begin
            step(vecs[i].rst, vecs[i].v1, vecs[i].d1, vecs[i].v2, vecs[i].d2, vecs[i].ordy);
            check($sformatf("vec%0d", i), 32'({s_grant, s_sr1, s_sr2, s_ov, s_od}),
                  32'({vecs[i].grant, vecs[i].sr1, vecs[i].sr2, vecs[i].ov, vecs[i].od}));
        end

        // Both masters stream: 4 beats of port 1, 4 of port 2, 4 of port 1.
        reset_dut();
        seq1 = '0; seq2 = '0; outq.delete();
        for (int c = 0; c < 60 && outq.size() < 12; c++) begin
            step(1'b0, 1'b1, 8'h10 + seq1, 1'b1, 8'h20 + seq2, 1'b1);
            if (s_ov) outq.push_back(s_od);
            if (s_x1) seq1++;
            if (s_x2) seq2++;
        end
        check("tie_count", 32'(outq.size()), 32'd12);
        for (int i = 0; i < 12 && i < outq.size(); i++) begin
            grp   = i / 4;
            idx   = (grp / 2) * 4 + i % 4;
            exp_b = ((grp % 2) == 0) ? 8'(8'h10 + idx) : 8'(8'h20 + idx);
            check($sformatf("tie_beat%0d", i), 32'(outq[i]), 32'(exp_b));
        end

        // Five-cycle downstream stall in the middle of a port-1 burst.
        reset_dut();
        seq1 = '0; seq2 = '0;
        for (int c = 0; c < 20 && seq1 < 2; c++) begin
            step(1'b0, 1'b1, 8'h30 + seq1, 1'b1, 8'h40 + seq2, 1'b1);
            if (s_x1) seq1++;
            if (s_x2) seq2++;
        end
        for (int k = 0; k < 5; k++) begin
            step(1'b0, 1'b1, 8'h30 + seq1, 1'b1, 8'h40 + seq2, 1'b0);
            check("stall_out", 32'({s_ov, s_od}), 32'({1'b1, 8'h31}));
            check("stall_ready", 32'({s_grant, s_sr1, s_sr2}), 32'({2'b01, 1'b0, 1'b0}));
            if (s_x1) seq1++;
            if (s_x2) seq2++;
        end
        outq.delete();
        for (int c = 0; c < 20 && outq.size() < 4; c++) begin
            step(1'b0, 1'b1, 8'h30 + seq1, 1'b1, 8'h40 + seq2, 1'b1);
            if (s_ov) outq.push_back(s_od);
            if (s_x1) seq1++;
            if (s_x2) seq2++;
        end
        check("stall_resume", 32'({outq.size() == 4 ? {outq[0], outq[1], outq[2], outq[3]} : 32'h0}),
              32'h31323340);

        // Owner drops valid after two beats while port 2 waits.
        reset_dut();
        seq1 = '0; seq2 = '0; outq.delete(); drop_age = 0;
        for (int c = 0; c < 30 && outq.size() < 4; c++) begin
            mv1 = (seq1 < 2);
            step(1'b0, mv1, 8'h50 + seq1, 1'b1, 8'h60 + seq2, 1'b1);
            if (!mv1) begin
                drop_age++;
                if (drop_age == 2) check("drop_grant", 32'(s_grant), 32'(2'b10));
            end
            if (s_ov) outq.push_back(s_od);
            if (s_x1) seq1++;
            if (s_x2) seq2++;
        end
        check("drop_beats", 32'({outq.size() == 4 ? {outq[0], outq[1], outq[2], outq[3]} : 32'h0}),
              32'h50516061);

        // Reset while a beat (0xA5) is buffered, then a tie goes to port 1.
        reset_dut();
        got = 1'b0;
        for (int c = 0; c < 10 && !got; c++) begin
            step(1'b0, 1'b1, 8'hA5, 1'b0, 8'h00, 1'b0);
            if (s_x1) got = 1'b1;
        end
        check("rst_load", 32'(got), 32'd1);
        step(1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
        check("rst_before", 32'({s_ov, s_od}), 32'({1'b1, 8'hA5}));
        step(1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
        step(1'b0, 1'b1, 8'hB1, 1'b1, 8'hC1, 1'b1);
        check("rst_cleared", 32'({s_grant, s_ov, s_od}), 32'({2'b00, 1'b0, 8'h00}));
        step(1'b0, 1'b1, 8'hB1, 1'b1, 8'hC1, 1'b1);
        check("rst_tie", 32'(s_grant), 32'(2'b01));

        // Random traffic; masters hold valid and data until accepted.
        reset_dut();
        mv1 = 1'b0; mv2 = 1'b0; md1 = '0; md2 = '0; s_x1 = 1'b0; s_x2 = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            if (!mv1 || s_x1) begin
                mv1 = ($urandom_range(0, 3) != 0);
                md1 = 8'($urandom);
            end
            if (!mv2 || s_x2) begin
                mv2 = ($urandom_range(0, 4) != 0);
                md2 = 8'($urandom);
            end
            step(($urandom_range(0, 199) == 0), mv1, md1, mv2, md2,
                 ($urandom_range(0, 9) < 7));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, checks passed %0d of %0d", n_pass, n_checks);
        $fatal(1, "watchdog expired");
    end
endmodule
